// File: rtl/image_median3x3_pkg.sv
// ----------------------------------------------------------------------------
// image_median3x3_pkg
// Shared constants and types for the 3x3 median filter.
//   PIX_W        : gray pixel width
//   MED_LATENCY  : cycles from the valid_i that completes a window to valid_o
//                  (window stage + three sort stages)
//   pix_t        : one gray pixel
// ----------------------------------------------------------------------------
package image_median3x3_pkg;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned MED_LATENCY = 4;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/image_median3x3_sort3.sv
// ----------------------------------------------------------------------------
// image_sort3
// Combinational 3-input unsigned sorter.
//   i_a, i_b, i_c : input pixels
//   o_max         : largest of the three
//   o_mid         : middle value
//   o_min         : smallest of the three
// Ties are harmless: equal values are interchangeable.
// ----------------------------------------------------------------------------
module image_sort3
    import image_median3x3_pkg::*;
(
    input  logic [PIX_W-1:0] i_a,
    input  logic [PIX_W-1:0] i_b,
    input  logic [PIX_W-1:0] i_c,
    output logic [PIX_W-1:0] o_max,
    output logic [PIX_W-1:0] o_mid,
    output logic [PIX_W-1:0] o_min
);

    pix_t w_ab_hi;
    pix_t w_ab_lo;

    always_comb begin
        w_ab_hi = (i_a > i_b) ? i_a : i_b;
        w_ab_lo = (i_a > i_b) ? i_b : i_a;
        o_max   = (w_ab_hi > i_c) ? w_ab_hi : i_c;
        o_min   = (w_ab_lo < i_c) ? w_ab_lo : i_c;
        // If c is at least the larger of a/b, that larger one is the middle;
        // otherwise the middle is the larger of c and the smaller of a/b.
        if (w_ab_hi > i_c) begin
            o_mid = (w_ab_lo > i_c) ? w_ab_lo : i_c;
        end else begin
            o_mid = w_ab_hi;
        end
    end

endmodule

// File: rtl/image_median3x3.sv
// ----------------------------------------------------------------------------
// image_median3x3
// 3x3 median filter over a raster-order gray image stream.
//   clk          : single clock, rising edge
//   reset        : asynchronous active-high reset
//   valid_i      : qualifies img_data_i (gaps allowed)
//   img_data_i   : gray input pixel
//   valid_o      : qualifies img_data_o
//   img_data_o   : median of the 3x3 window ending at the completing pixel
//   frame_done_o : pulse with the last output of a frame
// Border pixels (x<2 or y<2 at the window's lower-right corner) give no
// output, so (IMG_WIDTH-2)*(IMG_HEIGHT-2) results per frame.
// ----------------------------------------------------------------------------
module image_median3x3
    import image_median3x3_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [PIX_W-1:0] img_data_i,
    output logic             valid_o,
    output logic [PIX_W-1:0] img_data_o,
    output logic             frame_done_o
);

    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_win_done;

    pix_t r_lb1 [IMG_WIDTH];   // row y-1
    pix_t r_lb2 [IMG_WIDTH];   // row y-2
    pix_t w_lb1_rd;
    pix_t w_lb2_rd;

    // r_win[row][col]: row 0 = y-2, row 2 = current; col 2 = newest column
    pix_t r_win [3][3];
    logic r_win_v;
    logic r_win_last;

    pix_t w_s1_max [3];
    pix_t w_s1_mid [3];
    pix_t w_s1_min [3];
    pix_t r_s1_max [3];
    pix_t r_s1_mid [3];
    pix_t r_s1_min [3];
    logic r_s1_v;
    logic r_s1_last;

    pix_t w_s2_lo, w_s2_md, w_s2_hi;
    pix_t r_s2_lo, r_s2_md, r_s2_hi;
    logic r_s2_v;
    logic r_s2_last;
    pix_t w_med;

    pix_t w_u0_max, w_u0_mid, w_u1_max, w_u1_min, w_u2_mid, w_u2_min;
    pix_t w_u3_max, w_u3_min;
    logic w_unused;

    assign w_x_last   = (r_x == X_LAST);
    assign w_y_last   = (r_y == Y_LAST);
    assign w_win_done = valid_i && (r_x >= XW'(2)) && (r_y >= YW'(2));
    assign w_lb1_rd   = r_lb1[r_x];
    assign w_lb2_rd   = r_lb2[r_x];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (valid_i) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Line buffers: read-before-write at the same address; row y-1 cascades
    // into the y-2 buffer as the current row overwrites it.
    always_ff @(posedge clk) begin
        if (valid_i) begin
            r_lb1[r_x] <= img_data_i;
            r_lb2[r_x] <= w_lb1_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            r_win_v    <= 1'b0;
            r_win_last <= 1'b0;
        end else begin
            r_win_v    <= w_win_done;
            r_win_last <= w_win_done && w_x_last && w_y_last;
            if (valid_i) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb2_rd;
                r_win[1][2] <= w_lb1_rd;
                r_win[2][2] <= img_data_i;
            end
        end
    end

    // S1: sort each window row
    for (genvar g = 0; g < 3; g++) begin : g_s1
        image_sort3 u_sort_row (
            .i_a  (r_win[g][0]),
            .i_b  (r_win[g][1]),
            .i_c  (r_win[g][2]),
            .o_max(w_s1_max[g]),
            .o_mid(w_s1_mid[g]),
            .o_min(w_s1_min[g])
        );
    end

    // S2: min of maxes, mid of mids, max of mins
    image_sort3 u_sort_max (
        .i_a(r_s1_max[0]), .i_b(r_s1_max[1]), .i_c(r_s1_max[2]),
        .o_max(w_u0_max), .o_mid(w_u0_mid), .o_min(w_s2_lo)
    );
    image_sort3 u_sort_mid (
        .i_a(r_s1_mid[0]), .i_b(r_s1_mid[1]), .i_c(r_s1_mid[2]),
        .o_max(w_u1_max), .o_mid(w_s2_md), .o_min(w_u1_min)
    );
    image_sort3 u_sort_min (
        .i_a(r_s1_min[0]), .i_b(r_s1_min[1]), .i_c(r_s1_min[2]),
        .o_max(w_s2_hi), .o_mid(w_u2_mid), .o_min(w_u2_min)
    );

    // S3: median of the three candidates
    image_sort3 u_sort_med (
        .i_a(r_s2_lo), .i_b(r_s2_md), .i_c(r_s2_hi),
        .o_max(w_u3_max), .o_mid(w_med), .o_min(w_u3_min)
    );

    // Sort outputs the network does not need
    assign w_unused = ^{w_u0_max, w_u0_mid, w_u1_max, w_u1_min,
                        w_u2_mid, w_u2_min, w_u3_max, w_u3_min};

    // Free-running sort pipeline; valid/last tags travel with the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < 3; r++) begin
                r_s1_max[r] <= '0;
                r_s1_mid[r] <= '0;
                r_s1_min[r] <= '0;
            end
            r_s1_v       <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s2_lo      <= '0;
            r_s2_md      <= '0;
            r_s2_hi      <= '0;
            r_s2_v       <= 1'b0;
            r_s2_last    <= 1'b0;
            img_data_o   <= '0;
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < 3; r++) begin
                r_s1_max[r] <= w_s1_max[r];
                r_s1_mid[r] <= w_s1_mid[r];
                r_s1_min[r] <= w_s1_min[r];
            end
            r_s1_v       <= r_win_v;
            r_s1_last    <= r_win_last;
            r_s2_lo      <= w_s2_lo;
            r_s2_md      <= w_s2_md;
            r_s2_hi      <= w_s2_hi;
            r_s2_v       <= r_s1_v;
            r_s2_last    <= r_s1_last;
            img_data_o   <= w_med;
            valid_o      <= r_s2_v;
            frame_done_o <= r_s2_last;
        end
    end

endmodule

// File: tb/tb_image_median3x3.sv
// ----------------------------------------------------------------------------
// tb_image_median3x3
// Directed bench for image_median3x3 on an 8x6 image: constant, impulse,
// ramp (continuous and gapped), mid-frame reset and back-to-back frames.
// ----------------------------------------------------------------------------
module tb_image_median3x3;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       valid_i    = 1'b0;
    logic [7:0] img_data_i = 8'd0;
    logic       valid_o;
    logic [7:0] img_data_o;
    logic       frame_done_o;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int stray_fd = 0;
    int mx       = 0;
    int my       = 0;

    int oq_dat[$], oq_cyc[$], oq_fd[$];
    int eq_dat[$], eq_cyc[$], eq_fd[$];

    image_median3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (valid_i),
        .img_data_i  (img_data_i),
        .valid_o     (valid_o),
        .img_data_o  (img_data_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o) begin
            oq_dat.push_back(int'(img_data_o));
            oq_cyc.push_back(cyc);
            oq_fd.push_back(int'(frame_done_o));
        end else if (frame_done_o) begin
            stray_fd++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_queues();
        oq_dat.delete(); oq_cyc.delete(); oq_fd.delete();
        eq_dat.delete(); eq_cyc.delete(); eq_fd.delete();
    endtask

    // Drive one pixel; ev is the median expected if this pixel completes a window
    task automatic send(input int d, input int ev);
        @(negedge clk);
        valid_i    = 1'b1;
        img_data_i = d[7:0];
        if (mx >= 2 && my >= 2) begin
            eq_dat.push_back(ev);
            eq_cyc.push_back(cyc);
            eq_fd.push_back((mx == W-1 && my == H-1) ? 1 : 0);
        end
        if (mx == W-1) begin
            mx = 0;
            my = (my == H-1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
    endtask

    // mode 0: constant cval; 1: zero with 255 at (3,3); 2: ramp 10*x+y
    task automatic frame(input int mode, input int cval, input int gaps);
        int px, ev;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (mode)
                    0:       begin px = cval; ev = cval; end
                    1:       begin px = (x == 3 && y == 3) ? 255 : 0; ev = 0; end
                    default: begin px = 10*x + y; ev = 10*(x-1) + (y-1); end
                endcase
                send(px, ev);
                if (gaps != 0 && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++;
        if (img_data_o !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", img_data_o); end
        checks++;
        if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done_o); end
        reset = 1'b0;
        mx = 0; my = 0;
    endtask

    task automatic test_constant();
        int fds = 0;
        clear_queues();
        frame(0, 100, 0);
        idle(8);
        checks++;
        if (oq_dat.size() !== 24) begin errors++; $display("FAIL const_count: got %0d want 24", oq_dat.size()); end
        foreach (eq_dat[i]) if (i < oq_dat.size()) begin
            checks++;
            fds += oq_fd[i];
            if (oq_dat[i] !== 100 || oq_cyc[i] !== eq_cyc[i] + 4 || oq_fd[i] !== eq_fd[i]) begin
                errors++;
                $display("FAIL const_out[%0d]: got px=%0d cyc=%0d fd=%0d want px=100 cyc=%0d fd=%0d",
                         i, oq_dat[i], oq_cyc[i], oq_fd[i], eq_cyc[i] + 4, eq_fd[i]);
            end
        end
        checks++;
        if (fds !== 1) begin errors++; $display("FAIL const_fd_count: got %0d want 1", fds); end
    endtask

    task automatic test_impulse();
        clear_queues();
        frame(1, 0, 0);
        idle(8);
        checks++;
        if (oq_dat.size() !== 24) begin errors++; $display("FAIL impulse_count: got %0d want 24", oq_dat.size()); end
        foreach (oq_dat[i]) begin
            checks++;
            if (oq_dat[i] !== 0) begin errors++; $display("FAIL impulse_out[%0d]: got %0d want 0", i, oq_dat[i]); end
        end
    endtask

    task automatic test_ramp(input int gaps);
        clear_queues();
        frame(2, 0, gaps);
        idle(8);
        checks++;
        if (oq_dat.size() !== 24) begin errors++; $display("FAIL ramp_count(gaps=%0d): got %0d want 24", gaps, oq_dat.size()); end
        checks++;
        if (eq_dat.size() > 0 && eq_dat[0] !== 11) begin errors++; $display("FAIL ramp_first_exp: got %0d want 11", eq_dat[0]); end
        foreach (eq_dat[i]) if (i < oq_dat.size()) begin
            checks++;
            if (oq_dat[i] !== eq_dat[i] || oq_cyc[i] !== eq_cyc[i] + 4 || oq_fd[i] !== eq_fd[i]) begin
                errors++;
                $display("FAIL ramp_out[%0d](gaps=%0d): got px=%0d cyc=%0d fd=%0d want px=%0d cyc=%0d fd=%0d",
                         i, gaps, oq_dat[i], oq_cyc[i], oq_fd[i], eq_dat[i], eq_cyc[i] + 4, eq_fd[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int y = 0; y <= 3; y++) begin
            for (int x = 0; x < W; x++) begin
                if (!(y == 3 && x > 5)) send(10*x + y, 0);
            end
        end
        @(negedge clk);
        valid_i = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", valid_o); end
        @(negedge clk);
        reset = 1'b0;
        mx = 0; my = 0;
        clear_queues();
        frame(0, 50, 0);
        idle(8);
        checks++;
        if (oq_dat.size() !== 24) begin errors++; $display("FAIL midreset_count: got %0d want 24", oq_dat.size()); end
        foreach (eq_dat[i]) if (i < oq_dat.size()) begin
            checks++;
            if (oq_dat[i] !== 50 || oq_cyc[i] !== eq_cyc[i] + 4 || oq_fd[i] !== eq_fd[i]) begin
                errors++;
                $display("FAIL midreset_out[%0d]: got px=%0d cyc=%0d fd=%0d want px=50 cyc=%0d fd=%0d",
                         i, oq_dat[i], oq_cyc[i], oq_fd[i], eq_cyc[i] + 4, eq_fd[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int fds = 0;
        clear_queues();
        frame(2, 0, 0);
        frame(0, 7, 0);
        idle(8);
        checks++;
        if (oq_dat.size() !== 48) begin errors++; $display("FAIL b2b_count: got %0d want 48", oq_dat.size()); end
        foreach (eq_dat[i]) if (i < oq_dat.size()) begin
            checks++;
            fds += oq_fd[i];
            if (oq_dat[i] !== eq_dat[i] || oq_cyc[i] !== eq_cyc[i] + 4 || oq_fd[i] !== eq_fd[i]) begin
                errors++;
                $display("FAIL b2b_out[%0d]: got px=%0d cyc=%0d fd=%0d want px=%0d cyc=%0d fd=%0d",
                         i, oq_dat[i], oq_cyc[i], oq_fd[i], eq_dat[i], eq_cyc[i] + 4, eq_fd[i]);
            end
        end
        for (int i = 24; i < 48 && i < oq_dat.size(); i++) begin
            checks++;
            if (oq_dat[i] !== 7) begin errors++; $display("FAIL b2b_second[%0d]: got %0d want 7", i, oq_dat[i]); end
        end
        checks++;
        if (fds !== 2) begin errors++; $display("FAIL b2b_fd_count: got %0d want 2", fds); end
        checks++;
        if (stray_fd !== 0) begin errors++; $display("FAIL stray_frame_done: got %0d want 0", stray_fd); end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_impulse();
        test_ramp(0);
        test_ramp(1);
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_median3x3.md
IMAGE_MEDIAN3X3 -- requirements
Module: image_median3x3

Interface
REQ-001 Parameter IMG_WIDTH, default 640: active pixels per line (≥3).
REQ-002 Parameter IMG_HEIGHT, default 480: lines per frame (≥3).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 valid_i  input  1  qualifies img_data_i; one pixel per asserted cycle; gaps allowed.
REQ-006 img_data_i  input  8  gray pixel from the rgb2gray stage, raster order, frame starts after reset.
REQ-007 valid_o  output  1  qualifies img_data_o.
REQ-008 img_data_o  output  8  3x3 median pixel.
REQ-009 frame_done_o  output  1  one-cycle pulse coincident with the last output of a frame.

Function
REQ-010 Column counter x (0..IMG_WIDTH-1) and row counter y (0..IMG_HEIGHT-1) SHALL advance only on valid_i; x wraps to 0 and increments y; at (IMG_WIDTH-1, IMG_HEIGHT-1) both wrap to 0 (next frame).
REQ-011 Two line buffers of IMG_WIDTH x 8 bits SHALL hold rows y-1 and y-2, written/read at address x only on valid_i.
REQ-012 A 3x3 window register SHALL shift one column left on each valid_i, loading {row y-2, row y-1, current pixel} at column x.
REQ-013 A window is complete when valid_i is asserted with x≥2 and y≥2; only complete windows produce output; (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame; border pixels produce no output.
REQ-014 Median SHALL be computed by a 3-stage sort network: S1 sort each row (max/mid/min); S2 min-of-maxes, mid-of-mids, max-of-mins; S3 median of those three.
REQ-015 Latency: valid_o SHALL assert exactly 4 cycles after the valid_i cycle that completes a window (1 window stage + 3 sort stages); fixed, independent of input gaps.
REQ-016 Sort pipeline SHALL be free-running; a valid tag shifts alongside data; no backpressure exists.
REQ-017 Comparisons unsigned 8-bit; ties resolve to either equal value (result identical); no rounding or width growth.
REQ-018 frame_done_o SHALL assert with valid_o for the window completed at (IMG_WIDTH-1, IMG_HEIGHT-1), else 0.
REQ-019 Back-to-back frames SHALL be processed with no idle cycles required; line buffer contents from the previous frame are ignored because rows 0-1 produce no output.

Reset
REQ-020 On reset: x, y, valid pipeline tags, valid_o, frame_done_o, img_data_o SHALL be 0; window registers 0.
REQ-021 Line buffer RAM contents SHALL NOT require reset.
REQ-022 Reset asserted mid-frame SHALL discard in-flight results (no valid_o after release until a new complete window); the next pixel after release is (0,0).

Structure
REQ-023 Shared package/header SHALL hold PIX_W=8 and the median pipeline latency constant (4).
REQ-024 One sub-module image_sort3 (3-input → max/mid/min, combinational) SHALL be instantiated 7 times (3 in S1, 3 in S2 reuse mid/min/max outputs as needed, 1 in S3).
REQ-025 Line buffers SHALL be inferable as block/distributed RAM (single write, single read port).

Verification (bench IMG_WIDTH=8, IMG_HEIGHT=6)
REQ-026 Constant frame, all pixels 100, continuous valid_i → exactly 24 outputs, all 100, frame_done_o once on the 24th.
REQ-027 Zero frame with single 255 at (3,3) → all 24 outputs 0 (impulse removed).
REQ-028 Pixel = 10*x+y → each output equals center value 10*(x-1)+(y-1); first valid_o 4 cycles after input (2,2).
REQ-029 Same stimulus with valid_i toggled 1-0-1 randomly → identical output sequence; each valid_o 4 cycles after its completing input.
REQ-030 Assert reset after pixel (5,3) for 2 cycles, then full constant-50 frame → no output before new (2,2) window; then 24 outputs of 50.
REQ-031 Two back-to-back frames (ramp then constant 7) → second frame's 24 outputs all 7, two frame_done_o pulses.
